// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_sub_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor D = A - B, LSB first, one bit per clock through a single
// full-subtractor cell, started by a start pulse and finished with a one-cycle done pulse.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] qD,
    output logic         qBout
);

    state_e          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    // Upper W-1 result bits collected so far; the newest bit joins at the top.
    logic [W-2:0]    sr_q, sr_d;
    logic            borrow_q, borrow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    qd_q, qd_d;
    logic            qbout_q, qbout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            d_s;
    logic            bout_s;
    logic [W-1:0]    sr_ext_s;

    full_sub_bit u_cell (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .bin_i  (borrow_q),
        .d_o    (d_s),
        .bout_o (bout_s)
    );

    assign sr_ext_s = {d_s, sr_q};

    // Next-state, datapath and output-register update logic.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        qd_d     = qd_q;
        qbout_d  = qbout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d     = A;
                    sb_d     = B;
                    borrow_d = 1'b0;
                    cnt_d    = {CW{1'b0}};
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d     = {1'b0, sa_q[W-1:1]};
                sb_d     = {1'b0, sb_q[W-1:1]};
                sr_d     = sr_ext_s[W-1:1];
                borrow_d = bout_s;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(W - 1)) begin
                    qd_d    = sr_ext_s;
                    qbout_d = bout_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered decodes of the state being entered.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= {W{1'b0}};
            sb_q     <= {W{1'b0}};
            sr_q     <= {(W-1){1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            qd_q     <= {W{1'b0}};
            qbout_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            qd_q     <= qd_d;
            qbout_q  <= qbout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign qD    = qd_q;
    assign qBout = qbout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table, handshake corner cases,
// asynchronous reset mid-operation, and random operands on W=8 and W=5 instances.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic       busy8, done8, qbout8;
    logic [7:0] qd8;
    logic       start5 = 1'b0;
    logic [4:0] a5 = 5'd0, b5 = 5'd0;
    logic       busy5, done5, qbout5;
    logic [4:0] qd5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_sub #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .qD(qd8), .qBout(qbout8)
    );

    serial_sub #(.W(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .A(a5), .B(b5),
        .busy(busy5), .done(done5), .qD(qd5), .qBout(qbout5)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_bout;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one W=8 operation and reports done latency (edges after the accepting edge),
    // number of busy cycles and number of done pulses over a fixed 16-cycle window.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int bcyc, output int dones);
        a8 = a; b8 = b; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = -1; bcyc = 0; dones = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy8) bcyc++;
            if (done8) begin
                dones++;
                if (lat < 0) lat = i;
            end
            step();
        end
    endtask

    initial begin
        int lat, bcyc, dones;
        logic [8:0] ref8;
        logic [5:0] ref5;
        logic [7:0] got8;
        logic       gotb8;
        logic [4:0] got5;
        logic       gotb5;
        int n8, n5;

        vecs[0] = '{8'd5,   8'd3,   8'd2,   1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'd254, 1'b1};
        vecs[2] = '{8'd0,   8'd1,   8'd255, 1'b1};
        vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
        vecs[4] = '{8'd128, 8'd0,   8'd128, 1'b0};
        vecs[5] = '{8'd200, 8'd55,  8'd145, 1'b0};
        vecs[6] = '{8'd1,   8'd2,   8'd255, 1'b1};

        // Reset state.
        #2;
        chk("rst_busy",  32'(busy8),  32'd0);
        chk("rst_done",  32'(done8),  32'd0);
        chk("rst_qD",    32'(qd8),    32'd0);
        chk("rst_qBout", 32'(qbout8), 32'd0);
        chk("rst_qD5",   32'(qd5),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed table.
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, lat, bcyc, dones);
            chk($sformatf("vec%0d_lat", i),   32'(lat),    32'd8);
            chk($sformatf("vec%0d_busy", i),  32'(bcyc),   32'd9);
            chk($sformatf("vec%0d_dones", i), 32'(dones),  32'd1);
            chk($sformatf("vec%0d_qD", i),    32'(qd8),    32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_qBout", i), 32'(qbout8), 32'(vecs[i].exp_bout));
        end

        // 7 - 2 with start re-pulsed in RUN and DONE, operands changed mid-RUN.
        a8 = 8'd7; b8 = 8'd2; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'd100; b8 = 8'd200;
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 3) start8 = 1'b1;
            if (i == 4) begin
                start8 = 1'b0;
                chk("hold_qD_midrun",    32'(qd8),    32'd255);
                chk("hold_qBout_midrun", 32'(qbout8), 32'd1);
            end
            if (done8) begin
                dones++;
                start8 = 1'b1;
            end
            step();
            if (i > 4) start8 = 1'b0;
        end
        chk("busyign_dones", 32'(dones),  32'd1);
        chk("busyign_qD",    32'(qd8),    32'd5);
        chk("busyign_qBout", 32'(qbout8), 32'd0);
        chk("busyign_idle",  32'(busy8),  32'd0);

        // Asynchronous reset between edges in the middle of RUN.
        a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(busy8),  32'd0);
        chk("arst_done",  32'(done8),  32'd0);
        chk("arst_qD",    32'(qd8),    32'd0);
        chk("arst_qBout", 32'(qbout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) dones++;
            step();
        end
        chk("arst_nodone", 32'(dones), 32'd0);
        op8(8'd10, 8'd4, lat, bcyc, dones);
        chk("after_rst_qD",    32'(qd8),    32'd6);
        chk("after_rst_dones", 32'(dones),  32'd1);
        chk("after_rst_qBout", 32'(qbout8), 32'd0);

        // Random operands, both widths in lockstep.
        for (int k = 0; k < 200; k++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            a5 = 5'($urandom_range(0, 31));
            b5 = 5'($urandom_range(0, 31));
            ref8 = {1'b0, a8} - {1'b0, b8};
            ref5 = {1'b0, a5} - {1'b0, b5};
            start8 = 1'b1; start5 = 1'b1;
            step();
            start8 = 1'b0; start5 = 1'b0;
            n8 = 0; n5 = 0;
            got8 = 8'd0; gotb8 = 1'b0; got5 = 5'd0; gotb5 = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (done8) begin n8++; got8 = qd8; gotb8 = qbout8; end
                if (done5) begin n5++; got5 = qd5; gotb5 = qbout5; end
                step();
            end
            chk($sformatf("rnd8_%0d_dones", k), 32'(n8),    32'd1);
            chk($sformatf("rnd8_%0d_qD", k),    32'(got8),  32'(ref8[7:0]));
            chk($sformatf("rnd8_%0d_qBout", k), 32'(gotb8), 32'(ref8[8]));
            chk($sformatf("rnd5_%0d_dones", k), 32'(n5),    32'd1);
            chk($sformatf("rnd5_%0d_qD", k),    32'(got5),  32'(ref5[4:0]));
            chk($sformatf("rnd5_%0d_qBout", k), 32'(gotb5), 32'(ref5[5]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
